spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 181 ++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-written register bank with double-buffered, commit-gated outputs.
// Frames are ADDR_W address bits followed by DATA_W data bits, sent MSB first.
// A frame lands in a pending buffer, and a commit pulse copies pending buffers to the live outputs.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   spi_sclk/mosi/ss_n     raw SPI mode-0 inputs, asynchronous to clk
//   commit                 one-cycle pulse: pending buffers -> regs_flat
//   regs_flat              live values, register i at [i*DATA_W +: DATA_W]
//   pending                per-register uncommitted-write flags
//   wr_strobe              pulse on frame accepted
//   frame_err              pulse on frame discarded (bad address or short frame)
module spi_reg_bank #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         spi_sclk,
    input  logic                         spi_mosi,
    input  logic                         spi_ss_n,
    input  logic                         commit,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          pending,
    output logic                         wr_strobe,
    output logic                         frame_err
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                 r_mosi_s1, r_mosi_s2;
    logic                 r_ss_s1, r_ss_s2;
    logic                 r_armed;
    logic [CNT_W-1:0]     r_cnt;
    logic [FRAME_W-1:0]   r_shift;

    logic                 w_rise;
    logic [FRAME_W-1:0]   w_shift_nxt;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    logic                 w_addr_ok;
    logic                 w_clear;
    logic                 w_shift_en;
    logic                 w_accept;
    logic                 w_discard;

    assign w_rise      = r_sclk_s2 & ~r_sclk_s3;
    // Frame contents including the bit arriving this cycle, so the write lands on the completing edge
    assign w_shift_nxt = {r_shift[FRAME_W-2:0], r_mosi_s2};
    assign w_addr      = w_shift_nxt[FRAME_W-1 -: ADDR_W];
    assign w_data      = w_shift_nxt[DATA_W-1:0];
    assign w_addr_ok   = (32'(w_addr) < NUM_REGS);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and frame control
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_en  = 1'b0;
        w_accept    = 1'b0;
        w_discard   = 1'b0;
        case (r_state)
            IDLE: begin
                // r_armed blocks joining a frame that was already running when reset released
                if (r_armed && !r_ss_s2) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == CNT_W'(FRAME_W - 1)) begin
                        w_state_nxt = HOLD;
                        w_accept    = w_addr_ok;
                        w_discard   = ~w_addr_ok;
                    end
                end else if (r_ss_s2) begin
                    w_state_nxt = IDLE;
                    w_discard   = 1'b1;
                end
            end
            HOLD: begin
                if (r_ss_s2) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Synchronisers, shifter and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_ss_s1   <= 1'b0;
            r_ss_s2   <= 1'b0;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_ss_s1   <= spi_ss_n;
            r_ss_s2   <= r_ss_s1;
            if (r_ss_s2) begin
                r_armed <= 1'b1;
            end
            if (w_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_shift <= w_shift_nxt;
            end
            wr_strobe <= w_accept;
            frame_err <= w_discard;
        end
    end

    // Per-register pending buffer, live copy and pending flag
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] r_buf;
        logic [DATA_W-1:0] r_live;
        logic              r_pend;
        logic              w_hit;

        assign w_hit = w_accept && (w_addr == ADDR_W'(g));

        // Commit reads the old buffer; a same-cycle write stays pending
        always_ff @(posedge clk) begin
            if (reset) begin
                r_buf  <= '0;
                r_live <= '0;
                r_pend <= 1'b0;
            end else begin
                if (commit && r_pend) begin
                    r_live <= r_buf;
                end
                if (w_hit) begin
                    r_buf  <= w_data;
                    r_pend <= 1'b1;
                end else if (commit) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign regs_flat[g*DATA_W +: DATA_W] = r_live;
        assign pending[g]                    = r_pend;
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized self-checking bench for spi_reg_bank against an array-based model.
module tb_spi_reg_bank;

    localparam int unsigned NR = 12;
    localparam int unsigned DW = 24;
    localparam int unsigned AW = 4;
    localparam int unsigned FW = AW + DW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              spi_sclk = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_ss_n = 1'b1;
    logic              commit = 1'b0;
    logic [NR*DW-1:0]  regs_flat;
    logic [NR-1:0]     pending;
    logic              wr_strobe;
    logic              frame_err;

    spi_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_ss_n  (spi_ss_n),
        .commit    (commit),
        .regs_flat (regs_flat),
        .pending   (pending),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulses observed on the outputs
    int seen_strobe = 0;
    int seen_err    = 0;
    always @(negedge clk) begin
        if (wr_strobe) seen_strobe++;
        if (frame_err) seen_err++;
    end

    // Reference model
    logic [DW-1:0] m_buf  [NR];
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_pend;
    int            m_strobe = 0;
    int            m_err    = 0;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_flat();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) begin
            m_buf[i]  = '0;
            m_regs[i] = '0;
        end
        m_pend = '0;
    endtask

    task automatic m_commit();
        for (int i = 0; i < NR; i++) if (m_pend[i]) m_regs[i] = m_buf[i];
        m_pend = '0;
    endtask

    task automatic m_write(input int unsigned addr, input logic [DW-1:0] data);
        if (addr < NR) begin
            m_buf[addr]  = data;
            m_pend[addr] = 1'b1;
            m_strobe++;
        end else begin
            m_err++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pending"}, 320'(pending), 320'(m_pend));
        chk({tag, ".regs"}, 320'(regs_flat), 320'(exp_flat()));
        chk({tag, ".strobes"}, 320'(seen_strobe), 320'(m_strobe));
        chk({tag, ".errs"}, 320'(seen_err), 320'(m_err));
    endtask

    task automatic do_commit();
        @(posedge clk); #2 commit = 1'b1;
        @(posedge clk); #2 commit = 1'b0;
        m_commit();
        @(posedge clk);
    endtask

    // Send n bits: address, data, then random filler; optional reset after reset_at bits,
    // optional commit aligned with the acceptance edge.
    task automatic send_frame(input int unsigned addr, input int unsigned data, input int n,
                              input int reset_at, input bit commit_sync);
        logic [63:0] fr;
        bit          exp_acc;
        bit          valid;
        fr      = {AW'(addr), DW'(data), 36'({$urandom, $urandom})};
        exp_acc = (n >= int'(FW)) && (reset_at < 0);
        valid   = (addr < NR);
        @(posedge clk); #2 spi_ss_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2 spi_mosi = fr[63-k];
            repeat (2) @(posedge clk);
            #2 spi_sclk = 1'b1;
            if (k == int'(FW) - 1 && exp_acc) begin
                repeat (2) @(posedge clk);
                #1 chk("latency_early", 320'({wr_strobe, frame_err}), 320'(0));
                #1 if (commit_sync) commit = 1'b1;
                @(posedge clk);
                #1 chk("latency_edge3", 320'({wr_strobe, frame_err}), valid ? 320'(2) : 320'(1));
                commit = 1'b0;
                if (commit_sync) m_commit();
                m_write(addr, DW'(data));
            end else begin
                repeat (3) @(posedge clk);
            end
            @(posedge clk); #2 spi_sclk = 1'b0;
            if (k + 1 == reset_at) begin
                @(posedge clk); #2 reset = 1'b1;
                @(posedge clk); #2 reset = 1'b0;
                m_clear();
                chk("midframe_reset.pending", 320'(pending), 320'(0));
                chk("midframe_reset.regs", 320'(regs_flat), 320'(0));
            end
        end
        repeat (4) @(posedge clk);
        #2 spi_ss_n = 1'b1;
        if (n < int'(FW) && reset_at < 0) m_err++;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        m_clear();
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        check_all("reset");

        // Basic write then commit
        send_frame(3, 24'hABCDEF, FW, -1, 1'b0);
        chk("w3.pending_pre", 320'(pending), 320'(12'h008));
        check_all("w3");
        do_commit();
        check_all("w3_commit");

        // Out-of-range address
        send_frame(13, 24'h5A5A5A, FW, -1, 1'b0);
        check_all("addr13");

        // Short frame, then a good one
        send_frame(9, 24'h111111, 10, -1, 1'b0);
        check_all("short");
        send_frame(0, 24'h000055, FW, -1, 1'b0);
        check_all("after_short");

        // Overlong frame
        send_frame(5, 24'h123456, 32, -1, 1'b0);
        check_all("long");

        // Commit coincident with acceptance
        do_commit();
        send_frame(2, 24'hC0FFEE, FW, -1, 1'b0);
        send_frame(7, 24'h000001, FW, -1, 1'b1);
        chk("coincident.pending", 320'(pending), 320'(12'h080));
        check_all("coincident");
        do_commit();
        check_all("second_commit");

        // Reset part-way through a frame
        send_frame(4, 24'h0F0F0F, FW, 12, 1'b0);
        check_all("midreset");
        send_frame(6, 24'h777777, FW, -1, 1'b0);
        check_all("fresh_after_reset");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int unsigned op;
            int unsigned a;
            int unsigned d;
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, 15);
            d  = $urandom & 32'h00FF_FFFF;
            if (op < 2)       do_commit();
            else if (op == 2) send_frame(a, d, $urandom_range(1, FW - 1), -1, 1'b0);
            else if (op == 3) send_frame(a, d, $urandom_range(FW + 1, FW + 6), -1, 1'b0);
            else              send_frame(a, d, FW, -1, 1'b0);
            check_all("rand");
        end
        do_commit();
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
